em_array_pipe: RTL
==================

// Module: em_array_pipe
// PURPOSE
//  Parametrised, pipelined successor to the EU MAC carry-save multiplier array.
//  - Radix-4 Booth recodes A x B, merges an accumulator operand, rounding and negation.
//  - Reduces everything to a redundant SUM/CRY pair for the MAC final adder.
//  - Adds signed/unsigned operand modes, MPY/MAC/MSU ops, and a valid/ready pipeline with stall.
// PARAMETERS
//  A_W     16  multiplicand width (even, >=4)
//  B_W     16  multiplier width (even, >=4)
//  G_W      8  accumulator guard bits; ACC_W = A_W+B_W+G_W (default 40)
//  RND_POS 15  bit position of rounding constant (only with EM_ROUND_EN)
// PORTS
//  CLK        in   1      clock, rising edge
//  RST_N      in   1      synchronous reset, active low
//  IN_VLD_E   in   1      operand valid
//  IN_RDY_E   out  1      array can accept operands
//  OP_E       in   2      00 MPY, 01 MAC (acc+AxB), 10 MSU (acc-AxB), 11 reserved=MPY
//  SGN_A_E    in   1      1: A two's complement, 0: unsigned
//  SGN_B_E    in   1      1: B two's complement, 0: unsigned
//  RND_E      in   1      add 2^RND_POS (EM_ROUND_EN only)
//  MRa_E      in   A_W    multiplicand
//  MRb_E      in   B_W    multiplier
//  ACC_E      in   ACC_W  accumulator operand (used for MAC/MSU)
//  OUT_VLD_E  out  1      SUM/CRY valid
//  OUT_RDY_E  in   1      downstream final adder accepts
//  SUM_E      out  ACC_W  redundant sum row
//  CRY_E      out  ACC_W  redundant carry row (already weighted; result = SUM+CRY)
// BEHAVIOUR
//  - Reset (RST_N low at posedge): OUT_VLD_E=0, SUM_E=0, CRY_E=0, both stage valids 0.
//    IN_RDY_E=1 from the first cycle after reset. Reset mid-operation discards all in-flight data.
//  - Transfer rules: input accepted when IN_VLD_E&IN_RDY_E; output consumed when OUT_VLD_E&OUT_RDY_E.
//  - Stage S1 (Booth): sign/zero-extend A, B to A_W+1/B_W+2 bits per SGN_x.
//    Generates B_W/2+1 Booth partial products with sign-extension-constant encoding.
//    MSU: the two's-complement negation of AxB is encoded as inverted Booth digits plus hot-one
//    corrections. Registers the partial products, the correction bits, the operation-selected
//    accumulator (ACC_E for MAC/MSU, 0 for MPY) and the rounding bit.
//  - Stage S2 (tree): 3:2/4:2 compressor tree reduces S1 rows to SUM/CRY; registered outputs.
//  - Latency: 2 cycles from acceptance to OUT_VLD_E with no stall. Throughput: 1 per cycle.
//  - Arithmetic: SUM_E+CRY_E (mod 2^ACC_W) = acc +/- A*B (+ rnd).
//    Carries out of bit ACC_W-1 are dropped; no saturation in this block.
//  - Stall: OUT_VLD_E & ~OUT_RDY_E freezes S2 (SUM_E/CRY_E stable). S1 advances only if S2 is
//    empty or draining. IN_RDY_E = ~S1_vld | S2 advancing. No bubbles; no data loss.
//  - Simultaneous accept and drain in the same cycle is a full-rate pass-through.
//  - Inputs are don't-care when IN_VLD_E=0. Outputs are held, not cleared, after consumption
//    until overwritten.
//  - Back-to-back ops with different OP_E/SGN modes are independent; no state is shared across
//    operations.
// CONFIGURATION
//  EM_ROUND_EN defined:
//    RND_E adds 2^RND_POS as an extra tree row; S1 registers the rounding bit.
//  EM_ROUND_EN undefined:
//    RND_E is ignored, no rounding row or register; the tree is one row smaller.
//  Latency and handshake are identical in both builds.
// TESTING (defaults: A_W=B_W=16, G_W=8)
//  1 MPY, signed, A=B=0x7FFF -> 2 cycles later SUM+CRY=0x003FFF0001, OUT_VLD_E=1.
//  2 MPY, signed, A=B=0x8000 -> 0x0040000000.
//    MPY, unsigned, A=B=0xFFFF -> 0x00FFFE0001.
//  3 MAC, ACC=0x0000000001, A=0xFFFF(-1) signed, B=0x0001 -> 0x0000000000.
//    MSU, ACC=0, A=2, B=3 -> 0xFFFFFFFFFA.
//  4 Stream 8 back-to-back MACs, OUT_RDY_E low cycles 3-5:
//    - SUM/CRY held while stalled; IN_RDY_E low while S1 and S2 both full.
//    - All 8 results delivered in order, none duplicated.
//  5 Assert RST_N low for 1 cycle with 2 ops in flight -> next cycle OUT_VLD_E=0, SUM_E=CRY_E=0;
//    a new op issued after reset completes correctly.
//  6 EM_ROUND_EN: MPY A=0x4000 B=0x0001 RND_E=1 -> 0x000000C000.
//    Without EM_ROUND_EN the same stimulus -> 0x0000004000.

Source files
------------

// File: rtl/em_array_pipe.sv
// Two-stage Booth/carry-save multiplier array with MPY/MAC/MSU; EM_ROUND_EN adds a rounding row.
// Latency 2, one op per cycle; a stalled output freezes S2 and S1 refills only as S2 drains.
module em_array_pipe #(
  parameter int A_W     = 16,
  parameter int B_W     = 16,
  parameter int G_W     = 8,
  parameter int RND_POS = 15,
  localparam int ACC_W  = A_W + B_W + G_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VLD_E,
  output logic             IN_RDY_E,
  input  logic [1:0]       OP_E,
  input  logic             SGN_A_E,
  input  logic             SGN_B_E,
  input  logic             RND_E,
  input  logic [A_W-1:0]   MRa_E,
  input  logic [B_W-1:0]   MRb_E,
  input  logic [ACC_W-1:0] ACC_E,
  output logic             OUT_VLD_E,
  input  logic             OUT_RDY_E,
  output logic [ACC_W-1:0] SUM_E,
  output logic [ACC_W-1:0] CRY_E
);
  localparam int ND = B_W / 2 + 1;
  localparam int PW = A_W + 2;
`ifdef EM_ROUND_EN
  localparam int NR = ND + 4;
`else
  localparam int NR = ND + 3;
`endif

  // Each PP row is stored with its sign bit inverted; this constant restores the sign extension.
  function automatic logic [ACC_W-1:0] sext_const();
    logic [ACC_W-1:0] k;
    k = '0;
    for (int i = 0; i < ND; i++) k = k - (ACC_W'(1) << (PW - 1 + 2 * i));
    return k;
  endfunction
  localparam logic [ACC_W-1:0] K_ROW = sext_const();

  logic             s1_vld;
  logic [PW-1:0]    s1_pp [ND];
  logic [ND-1:0]    s1_neg;
  logic [ACC_W-1:0] s1_acc;
  logic             s2_adv;

  logic [PW-1:0]    pp_d [ND];
  logic [ND-1:0]    neg_d;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_d, cry_d;

  assign s2_adv   = ~OUT_VLD_E | OUT_RDY_E;
  assign IN_RDY_E = ~s1_vld | s2_adv;

  always_comb begin
    logic [A_W:0]   ax;
    logic [B_W+2:0] bxe;
    logic [2:0]     trip;
    logic [PW-1:0]  sel, r;
    logic           msu, one, two, ng;
    ax    = {SGN_A_E & MRa_E[A_W-1], MRa_E};
    bxe   = {{2{SGN_B_E & MRb_E[B_W-1]}}, MRb_E, 1'b0};
    msu   = (OP_E == 2'b10);
    acc_d = (OP_E == 2'b01 || OP_E == 2'b10) ? ACC_E : '0;
    neg_d = '0;
    for (int i = 0; i < ND; i++) begin
      trip = bxe[2*i +: 3];
      one  = trip[1] ^ trip[0];
      two  = (trip == 3'b100) | (trip == 3'b011);
      // MSU flips every digit's sign so the rows sum to -(A*B).
      ng   = trip[2] ^ msu;
      sel  = one ? {ax[A_W], ax} : (two ? {ax, 1'b0} : '0);
      r    = ng ? ~sel : sel;
      pp_d[i]  = {~r[PW-1], r[PW-2:0]};
      neg_d[i] = ng;
    end
  end

  always_ff @(posedge CLK) begin
    if (IN_RDY_E && IN_VLD_E) begin
      s1_pp  <= pp_d;
      s1_neg <= neg_d;
      s1_acc <= acc_d;
    end
  end

`ifdef EM_ROUND_EN
  logic s1_rnd;
  always_ff @(posedge CLK) begin
    if (!RST_N)                       s1_rnd <= 1'b0;
    else if (IN_RDY_E && IN_VLD_E)    s1_rnd <= RND_E;
  end
`else
  logic unused_rnd;
  assign unused_rnd = RND_E;
`endif

  always_comb begin
    logic [ACC_W-1:0] rows [NR];
    logic [ACC_W-1:0] nrow, s, c, t;
    nrow = '0;
    for (int i = 0; i < ND; i++) begin
      rows[i]     = ACC_W'(s1_pp[i]) << (2 * i);
      nrow[2*i]   = s1_neg[i];
    end
    rows[ND]     = nrow;
    rows[ND + 1] = K_ROW;
    rows[ND + 2] = s1_acc;
`ifdef EM_ROUND_EN
    rows[ND + 3] = ACC_W'(s1_rnd) << RND_POS;
`endif
    // 3:2 carry-save chain; carries out of the top bit are dropped.
    s = rows[0];
    c = rows[1];
    for (int k = 2; k < NR; k++) begin
      t = s ^ c ^ rows[k];
      c = ((s & c) | (s & rows[k]) | (c & rows[k])) << 1;
      s = t;
    end
    sum_d = s;
    cry_d = c;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_vld    <= 1'b0;
      OUT_VLD_E <= 1'b0;
      SUM_E     <= '0;
      CRY_E     <= '0;
    end else begin
      if (IN_RDY_E) s1_vld <= IN_VLD_E;
      if (s2_adv) begin
        OUT_VLD_E <= s1_vld;
        if (s1_vld) begin
          SUM_E <= sum_d;
          CRY_E <= cry_d;
        end
      end
    end
  end
endmodule
